// File: rtl/wb_pkg.sv
// Shared constants for the writeback/commit stage: CP0 addresses, ExcCodes,
// exception request bit positions and CP0 reset images.
package wb_pkg;

    localparam logic [7:0] CP0_BADVADDR = 8'h40;
    localparam logic [7:0] CP0_COUNT    = 8'h48;
    localparam logic [7:0] CP0_COMPARE  = 8'h58;
    localparam logic [7:0] CP0_STATUS   = 8'h60;
    localparam logic [7:0] CP0_CAUSE    = 8'h68;
    localparam logic [7:0] CP0_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int unsigned EXB_ADEL_IF = 0;
    localparam int unsigned EXB_RI      = 1;
    localparam int unsigned EXB_OV      = 2;
    localparam int unsigned EXB_SYS     = 3;
    localparam int unsigned EXB_BP      = 4;
    localparam int unsigned EXB_ADEL_D  = 5;
    localparam int unsigned EXB_ADES    = 6;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] CAUSE_RST  = 32'h0000_0000;

    // Highest-priority cause wins; interrupts outrank every synchronous exception.
    function automatic logic [4:0] exc_code(input logic irq, input logic [6:0] exc);
        if (irq)                     return EXC_INT;
        if (exc[EXB_ADEL_IF])        return EXC_ADEL;
        if (exc[EXB_RI])             return EXC_RI;
        if (exc[EXB_OV])             return EXC_OV;
        if (exc[EXB_SYS])            return EXC_SYS;
        if (exc[EXB_BP])             return EXC_BP;
        if (exc[EXB_ADEL_D])         return EXC_ADEL;
        if (exc[EXB_ADES])           return EXC_ADES;
        return EXC_INT;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match and sticky TI flag.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             adv_q, adv_d;

    // Software writes are applied last so they override the hardware update.
    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        adv_d     = adv_q;
        if (div_q == DIV_W'(COUNT_DIV - 1)) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
            adv_d   = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if ((count_q == compare_q) && ((compare_q != 32'd0) || adv_q)) begin
            ti_d = 1'b1;
        end
        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = '0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            adv_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            adv_q     <= adv_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage with CP0 (Status/Cause/EPC/BadVAddr + timer),
// exception prioritisation, single flush/redirect and register-file write.
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned HW_INT_NUM = 6,
    parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_valid,
    output logic                  ws_allowin,
    input  logic [31:0]           ms_pc,
    input  logic                  ms_bd,
    input  logic [7:0]            ms_exc,
    input  logic [31:0]           ms_badvaddr,
    input  logic                  ms_eret,
    input  logic                  ms_cp0_wen,
    input  logic                  ms_cp0_ren,
    input  logic [7:0]            ms_cp0_addr,
    input  logic [3:0]            ms_gr_we,
    input  logic [4:0]            ms_dest,
    input  logic [DATA_W-1:0]     ms_result,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic [3:0]            rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  fwd_valid,
    output logic [3:0]            fwd_we,
    output logic [4:0]            fwd_dest,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);

    logic              ws_valid_q;
    logic [31:0]       ws_pc_q;
    logic              ws_bd_q;
    logic [6:0]        ws_exc_q;
    logic [31:0]       ws_badvaddr_q;
    logic              ws_eret_q;
    logic              ws_cp0_wen_q;
    logic              ws_cp0_ren_q;
    logic [7:0]        ws_cp0_addr_q;
    logic [3:0]        ws_gr_we_q;
    logic [4:0]        ws_dest_q;
    logic [DATA_W-1:0] ws_result_q;

    logic [7:0]  status_im_q, status_im_d;
    logic        status_exl_q, status_exl_d;
    logic        status_ie_q, status_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_hw_q;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        ready_go;
    logic        active;
    logic        int_req;
    logic        take_exc;
    logic        cp0_we;
    logic [4:0]  exc_code_w;
    logic [7:0]  cause_ip;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_wdata;
    logic [31:0] timer_count;
    logic [31:0] timer_compare;
    logic        timer_ti;
    logic        unused_ms_exc7;

    assign unused_ms_exc7 = ms_exc[7];
    assign ready_go       = 1'b1;
    assign ws_allowin     = !ws_valid_q || ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
        end else if (flush) begin
            ws_valid_q <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid_q <= ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_valid && ws_allowin) begin
            ws_pc_q       <= ms_pc;
            ws_bd_q       <= ms_bd;
            ws_exc_q      <= ms_exc[6:0];
            ws_badvaddr_q <= ms_badvaddr;
            ws_eret_q     <= ms_eret;
            ws_cp0_wen_q  <= ms_cp0_wen;
            ws_cp0_ren_q  <= ms_cp0_ren;
            ws_cp0_addr_q <= ms_cp0_addr;
            ws_gr_we_q    <= ms_gr_we;
            ws_dest_q     <= ms_dest;
            ws_result_q   <= ms_result;
        end
    end

    // The WB instruction is dropped outright while reset is held.
    assign active     = ws_valid_q && !reset;
    assign cause_ip   = {cause_ip_hw_q[5] | timer_ti, cause_ip_hw_q[4:0], cause_ip_sw_q};
    assign int_req    = active && status_ie_q && !status_exl_q && |(cause_ip & status_im_q);
    assign take_exc   = active && (int_req || |ws_exc_q);
    assign exc_code_w = exc_code(int_req, ws_exc_q);
    assign cp0_we     = active && ws_cp0_wen_q && !take_exc;
    assign cp0_wdata  = 32'(ws_result_q);

    assign flush    = take_exc || (active && ws_eret_q);
    assign flush_pc = take_exc ? EXC_VEC : epc_q;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .count_we_i   (cp0_we && (ws_cp0_addr_q == CP0_COUNT)),
        .compare_we_i (cp0_we && (ws_cp0_addr_q == CP0_COMPARE)),
        .wdata_i      (cp0_wdata),
        .count_o      (timer_count),
        .compare_o    (timer_compare),
        .ti_o         (timer_ti)
    );

    always_comb begin
        cp0_rdata = 32'd0;
        case (ws_cp0_addr_q)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = timer_count;
            CP0_COMPARE:  cp0_rdata = timer_compare;
            CP0_STATUS:   cp0_rdata = STATUS_RST | {16'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
            CP0_CAUSE:    cp0_rdata = {cause_bd_q, timer_ti, 14'd0, cause_ip, 1'b0, cause_exc_q, 2'd0};
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    // Exception entry overrides ERET, which overrides an MTC0 to EXL.
    always_comb begin
        status_im_d   = status_im_q;
        status_exl_d  = status_exl_q;
        status_ie_d   = status_ie_q;
        cause_bd_d    = cause_bd_q;
        cause_ip_sw_d = cause_ip_sw_q;
        cause_exc_d   = cause_exc_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        if (cp0_we) begin
            case (ws_cp0_addr_q)
                CP0_STATUS: begin
                    status_im_d  = cp0_wdata[15:8];
                    status_exl_d = cp0_wdata[1];
                    status_ie_d  = cp0_wdata[0];
                end
                CP0_CAUSE: cause_ip_sw_d = cp0_wdata[9:8];
                CP0_EPC:   epc_d         = cp0_wdata;
                default: ;
            endcase
        end
        if (active && ws_eret_q && !take_exc) begin
            status_exl_d = 1'b0;
        end
        if (take_exc) begin
            cause_exc_d = exc_code_w;
            if (!status_exl_q) begin
                epc_d        = ws_bd_q ? (ws_pc_q - 32'd4) : ws_pc_q;
                cause_bd_d   = ws_bd_q;
                status_exl_d = 1'b1;
            end
            if ((exc_code_w == EXC_ADEL) && ws_exc_q[EXB_ADEL_IF]) begin
                badvaddr_d = ws_pc_q;
            end else if ((exc_code_w == EXC_ADEL) || (exc_code_w == EXC_ADES)) begin
                badvaddr_d = ws_badvaddr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_im_d_reset: begin
                status_im_q   <= STATUS_RST[15:8];
                status_exl_q  <= STATUS_RST[1];
                status_ie_q   <= STATUS_RST[0];
            end
            cause_bd_q    <= CAUSE_RST[31];
            cause_ip_hw_q <= CAUSE_RST[15:10];
            cause_ip_sw_q <= CAUSE_RST[9:8];
            cause_exc_q   <= CAUSE_RST[6:2];
            epc_q         <= 32'd0;
            badvaddr_q    <= 32'd0;
        end else begin
            status_im_q   <= status_im_d;
            status_exl_q  <= status_exl_d;
            status_ie_q   <= status_ie_d;
            cause_bd_q    <= cause_bd_d;
            cause_ip_hw_q <= 6'(hw_int);
            cause_ip_sw_q <= cause_ip_sw_d;
            cause_exc_q   <= cause_exc_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
        end
    end

    assign rf_we    = ws_gr_we_q & {4{active && !take_exc}};
    assign rf_waddr = ws_dest_q;
    assign rf_wdata = ws_cp0_ren_q ? DATA_W'(cp0_rdata) : ws_result_q;

    assign fwd_valid = active;
    assign fwd_we    = rf_we;
    assign fwd_dest  = ws_dest_q;
    assign fwd_data  = rf_wdata;

    assign debug_wb_pc       = ws_pc_q;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = ws_dest_q;
    assign debug_wb_rf_wdata = 32'(rf_wdata);

endmodule

// File: tb/tb_wb_commit_unit.sv
// Randomised and directed bench for wb_commit_unit against a behavioural CP0 model.
module tb_wb_commit_unit;

    localparam int unsigned HWN = 4;
    localparam int unsigned DIV = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    localparam logic [7:0] A_BVA = 8'h40, A_CNT = 8'h48, A_CMP = 8'h58;
    localparam logic [7:0] A_ST  = 8'h60, A_CA  = 8'h68, A_EPC = 8'h70;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [7:0]  exc;
        logic [31:0] bva;
        logic        eret;
        logic        wen;
        logic        ren;
        logic [7:0]  addr;
        logic [3:0]  gwe;
        logic [4:0]  dest;
        logic [31:0] res;
    } instr_t;

    logic clk, reset;
    logic ms_valid, ws_allowin, ms_bd, ms_eret, ms_cp0_wen, ms_cp0_ren;
    logic [31:0] ms_pc, ms_badvaddr, ms_result;
    logic [7:0] ms_exc, ms_cp0_addr;
    logic [3:0] ms_gr_we;
    logic [4:0] ms_dest;
    logic [HWN-1:0] hw_int;
    logic [3:0] rf_we, fwd_we, debug_wb_rf_wen;
    logic [4:0] rf_waddr, fwd_dest, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, fwd_data, flush_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic fwd_valid, flush;

    wb_commit_unit #(
        .DATA_W(32), .HW_INT_NUM(HWN), .EXC_VEC(VEC), .COUNT_DIV(DIV)
    ) dut (
        .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_exc(ms_exc), .ms_badvaddr(ms_badvaddr),
        .ms_eret(ms_eret), .ms_cp0_wen(ms_cp0_wen), .ms_cp0_ren(ms_cp0_ren),
        .ms_cp0_addr(ms_cp0_addr), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
        .ms_result(ms_result), .hw_int(hw_int), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .flush(flush), .flush_pc(flush_pc), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural model state
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_adv;
    logic [5:0]  m_hw;
    logic [1:0]  m_sw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bva, m_base, m_cyc, m_compare;
    instr_t      w;
    logic [3:0]  cur_hw;

    logic        e_take, e_flush;
    logic [31:0] e_fpc, e_wdata;
    logic [3:0]  e_rfwe;
    logic [4:0]  e_code;

    function automatic logic [31:0] m_count();
        return m_base + m_cyc / 32'(DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_BVA:   return m_bva;
            A_CNT:   return m_count();
            A_CMP:   return m_compare;
            A_ST:    return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
            A_CA:    return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'd0};
            A_EPC:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_eval();
        logic [4:0] codes [7];
        logic irq;
        codes = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
        irq    = w.valid && m_ie && !m_exl && |(m_ip() & m_im);
        e_take = w.valid && (irq || |w.exc[6:0]);
        e_code = 5'h00;
        if (!irq) begin
            for (int i = 6; i >= 0; i--) if (w.exc[i]) e_code = codes[i];
        end
        e_flush = e_take || (w.valid && w.eret);
        e_fpc   = e_take ? VEC : m_epc;
        e_rfwe  = (w.valid && !e_take) ? w.gwe : 4'h0;
        e_wdata = w.ren ? m_read(w.addr) : w.res;
    endtask

    task automatic model_reset();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_adv = 0;
        m_hw = 0; m_sw = 0; m_exc = 0; m_epc = 0; m_bva = 0;
        m_base = 0; m_cyc = 0; m_compare = 0; w = '0;
    endtask

    task automatic model_edge(input instr_t ins, input logic [3:0] hw);
        logic ti_n, tick;
        m_eval();
        ti_n = m_ti || ((m_count() == m_compare) && (m_compare != 0 || m_adv));
        tick = (m_cyc % 32'(DIV)) == 32'(DIV - 1);
        m_adv = m_adv || tick;
        m_cyc = m_cyc + 1;
        if (e_take) begin
            m_exc = e_code;
            if (!m_exl) begin
                m_epc = w.bd ? w.pc - 32'd4 : w.pc;
                m_bd  = w.bd;
                m_exl = 1'b1;
            end
            if (e_code == 5'h04 && w.exc[0]) m_bva = w.pc;
            else if (e_code == 5'h04 || e_code == 5'h05) m_bva = w.bva;
        end else if (w.valid) begin
            if (w.wen) begin
                case (w.addr)
                    A_CNT: begin m_base = w.res; m_cyc = 0; end
                    A_CMP: begin m_compare = w.res; ti_n = 1'b0; end
                    A_ST:  begin m_im = w.res[15:8]; m_exl = w.res[1]; m_ie = w.res[0]; end
                    A_CA:  m_sw = w.res[9:8];
                    A_EPC: m_epc = w.res;
                    default: ;
                endcase
            end
            if (w.eret) m_exl = 1'b0;
        end
        m_ti = ti_n;
        m_hw = 6'(hw);
        w = ins;
        w.valid = ins.valid && !e_flush;
    endtask

    task automatic check_outputs();
        m_eval();
        chk("flush", 32'(flush), 32'(e_flush));
        chk("flush_pc", flush_pc, e_fpc);
        chk("rf_we", 32'(rf_we), 32'(e_rfwe));
        chk("fwd_valid", 32'(fwd_valid), 32'(w.valid));
        chk("dbg_wen", 32'(debug_wb_rf_wen), 32'(e_rfwe));
        if (e_rfwe != 4'h0) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(w.dest));
            chk("rf_wdata", rf_wdata, e_wdata);
            chk("fwd_data", fwd_data, e_wdata);
            chk("dbg_pc", debug_wb_pc, w.pc);
            chk("dbg_wdata", debug_wb_rf_wdata, e_wdata);
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic cycle(input instr_t ins);
        ms_valid = ins.valid; ms_pc = ins.pc; ms_bd = ins.bd; ms_exc = ins.exc;
        ms_badvaddr = ins.bva; ms_eret = ins.eret; ms_cp0_wen = ins.wen;
        ms_cp0_ren = ins.ren; ms_cp0_addr = ins.addr; ms_gr_we = ins.gwe;
        ms_dest = ins.dest; ms_result = ins.res; hw_int = cur_hw;
        @(posedge clk);
        model_edge(ins, cur_hw);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ms_valid = 1'b0;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic instr_t nop_i();
        return '0;
    endfunction
    function automatic instr_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
        instr_t i = '0;
        i.valid = 1; i.pc = pc; i.gwe = 4'hF; i.dest = d; i.res = r;
        return i;
    endfunction
    function automatic instr_t mfc0(input logic [7:0] a);
        instr_t i = alu(32'h1000, 5'd2, 32'h0);
        i.ren = 1; i.addr = a;
        return i;
    endfunction
    function automatic instr_t mtc0(input logic [7:0] a, input logic [31:0] d);
        instr_t i = '0;
        i.valid = 1; i.pc = 32'h2000; i.wen = 1; i.addr = a; i.res = d;
        return i;
    endfunction
    function automatic instr_t excp(input logic [31:0] pc, input logic bd, input logic [7:0] e, input logic [31:0] bva);
        instr_t i = alu(pc, 5'd3, 32'h77);
        i.bd = bd; i.exc = e; i.bva = bva;
        return i;
    endfunction
    function automatic instr_t eret_i();
        instr_t i = '0;
        i.valid = 1; i.pc = 32'h3000; i.eret = 1;
        return i;
    endfunction

    initial begin
        logic [7:0] addrs [8];
        instr_t ins;
        int k;
        addrs = '{A_BVA, A_CNT, A_CMP, A_ST, A_CA, A_EPC, 8'h00, 8'h61};
        reset = 1'b1; cur_hw = '0; hw_int = '0;
        ms_valid = 0; ms_pc = 0; ms_bd = 0; ms_exc = 0; ms_badvaddr = 0; ms_eret = 0;
        ms_cp0_wen = 0; ms_cp0_ren = 0; ms_cp0_addr = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("post_rst_fwd_valid", 32'(fwd_valid), 32'h0);

        cycle(mfc0(A_ST));  chk("status_rst", rf_wdata, 32'h0040_0000);
        cycle(mfc0(A_CA));  chk("cause_rst", rf_wdata, 32'h0);
        cycle(alu(32'hBFC00000, 5'd5, 32'h1234));
        chk("addu_we", 32'(rf_we), 32'hF);
        chk("addu_waddr", 32'(rf_waddr), 32'd5);
        chk("addu_wdata", rf_wdata, 32'h1234);
        chk("addu_flush", 32'(flush), 32'h0);

        cycle(excp(32'hBFC00100, 1'b1, 8'h08, 32'h0));
        chk("sys_flush", 32'(flush), 32'h1);
        chk("sys_fpc", flush_pc, 32'hBFC00380);
        chk("sys_rfwe", 32'(rf_we), 32'h0);
        cycle(nop_i());
        cycle(mfc0(A_EPC)); chk("sys_epc", rf_wdata, 32'hBFC000FC);
        cycle(mfc0(A_CA));  chk("sys_cause", rf_wdata, 32'h8000_0020);
        cycle(mfc0(A_ST));  chk("sys_exl", rf_wdata, 32'h0040_0002);
        cycle(eret_i());
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_fpc", flush_pc, 32'hBFC000FC);
        cycle(nop_i());
        cycle(mfc0(A_ST));  chk("eret_exl", rf_wdata, 32'h0040_0000);

        cycle(excp(32'h100, 1'b0, 8'h08, 32'h0));
        cycle(nop_i());
        cycle(excp(32'h200, 1'b0, 8'h02, 32'h0));
        cycle(nop_i());
        cycle(mfc0(A_EPC)); chk("nested_epc", rf_wdata, 32'h100);
        cycle(mfc0(A_CA));  chk("nested_code", 32'(rf_wdata[6:2]), 32'h0A);
        cycle(eret_i()); cycle(nop_i());

        cycle(excp(32'h300, 1'b0, 8'h44, 32'hDEAD0000));
        cycle(nop_i());
        cycle(mfc0(A_CA));  chk("ov_ades_code", 32'(rf_wdata[6:2]), 32'h0C);
        cycle(mfc0(A_BVA)); chk("ov_ades_bva", rf_wdata, 32'h0);
        cycle(eret_i()); cycle(nop_i());
        cycle(excp(32'h340, 1'b0, 8'h80, 32'h0));
        chk("exc7_ignored", 32'(flush), 32'h0);
        cycle(excp(32'h1, 1'b0, 8'h01, 32'h5555));
        cycle(nop_i());
        cycle(mfc0(A_BVA)); chk("adel_if_bva", rf_wdata, 32'h1);
        cycle(eret_i()); cycle(nop_i());
        cycle(excp(32'h400, 1'b0, 8'h20, 32'h12345678));
        cycle(nop_i());
        cycle(mfc0(A_BVA)); chk("adel_d_bva", rf_wdata, 32'h12345678);
        cycle(eret_i()); cycle(nop_i());

        cycle(mtc0(A_CMP, 32'd10));
        cycle(mtc0(A_CNT, 32'd0));
        cycle(mtc0(A_ST, 32'h0000_8001));
        repeat (24) cycle(nop_i());
        cycle(alu(32'h500, 5'd4, 32'h9));
        chk("timer_int_flush", 32'(flush), 32'h1);
        chk("timer_int_rfwe", 32'(rf_we), 32'h0);
        cycle(nop_i());
        cycle(mfc0(A_CA));
        chk("timer_int_code", 32'(rf_wdata[6:2]), 32'h00);
        chk("timer_ti_set", 32'(rf_wdata[30]), 32'h1);
        cycle(mtc0(A_CMP, 32'hFFFF_0000));
        cycle(mfc0(A_CA));  chk("timer_ti_clr", 32'(rf_wdata[30]), 32'h0);
        cycle(mtc0(A_ST, 32'h0));

        cur_hw = 4'h1;
        cycle(mtc0(A_ST, 32'h0000_0400));
        cycle(alu(32'h600, 5'd6, 32'h1));
        chk("hw_ie0_noflush", 32'(flush), 32'h0);
        cycle(mfc0(A_CA));  chk("hw_ip2", 32'(rf_wdata[10]), 32'h1);
        cur_hw = 4'hF;
        cycle(nop_i());
        cycle(mfc0(A_CA));
        chk("hw_ip_lo", 32'(rf_wdata[13:10]), 32'hF);
        chk("hw_ip_absent", 32'(rf_wdata[15:14]), 32'h0);
        cur_hw = 4'h0;

        cycle(alu(32'h700, 5'd7, 32'hABCD));
        do_reset();
        cycle(mfc0(A_ST));  chk("mid_rst_status", rf_wdata, 32'h0040_0000);

        for (int n = 0; n < 500; n++) begin
            ins = '0;
            ins.valid = $urandom_range(0, 99) < 85;
            ins.pc    = $urandom;
            ins.bd    = 1'($urandom);
            ins.dest  = 5'($urandom);
            ins.gwe   = 4'($urandom);
            ins.res   = $urandom;
            k = $urandom_range(0, 9);
            if (k == 4 || k == 5) begin
                ins.ren = 1; ins.addr = addrs[$urandom_range(0, 7)];
            end else if (k == 6 || k == 7) begin
                ins.wen = 1; ins.gwe = 4'h0; ins.addr = addrs[$urandom_range(0, 7)];
                if (ins.addr == A_CMP) ins.res = m_count() + 32'($urandom_range(2, 40));
            end else if (k == 8) begin
                ins.exc = 8'($urandom);
                ins.bva = $urandom;
            end else if (k == 9) begin
                ins.eret = 1; ins.gwe = 4'h0;
            end
            if ($urandom_range(0, 7) == 0) cur_hw = 4'($urandom);
            cycle(ins);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
